// File: rtl/reset_sequencer.sv
// reset_sequencer: board-level reset conditioner. Synchronises and debounces
// asynchronous reset requests, watches lock/ready flags, stretches a reset
// pulse, then releases N_STAGES reset outputs one after another. Also keeps
// the cause of the last reset and a saturating count of reset events.
module reset_sequencer #(
  parameter int N_REQ           = 2,
  parameter int N_LOCK          = 2,
  parameter int SYNC_DEPTH      = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 32,
  parameter int N_STAGES        = 3,
  parameter int STAGE_GAP       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_LOCK-1:0]   lock,
  output logic [N_STAGES-1:0] rst_out,
  output logic                busy,
  output logic [N_REQ:0]      cause,
  output logic [7:0]          event_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

  localparam logic [N_STAGES-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    HOLD,
    WAIT_LOCK,
    RELEASE,
    RUN
  } state_t;

  state_t state;

  logic [SYNC_DEPTH-1:0][N_REQ-1:0]  req_sync;
  logic [SYNC_DEPTH-1:0][N_LOCK-1:0] lock_sync;
  logic [N_REQ-1:0]                  req_s;
  logic [N_LOCK-1:0]                 lock_s;

  logic [DW-1:0]    deb_cnt [N_REQ];
  logic [N_REQ-1:0] deb_lvl;
  logic [N_REQ-1:0] deb_lvl_q;
  logic [N_REQ-1:0] req_trig;

  logic          lock_ok;
  logic          lock_loss;
  logic [N_REQ:0] trig_bits;
  logic          trig_any;

  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] stage;
  logic [GW-1:0] gap;

  assign req_s  = req_sync[SYNC_DEPTH-1];
  assign lock_s = lock_sync[SYNC_DEPTH-1];

  // Synchroniser chains: inputs enter at index 0 and are used only at the end.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // with = the chain would collapse into a single stage.
    if (reset) begin
      req_sync  <= '0;
      lock_sync <= '0;
    end else begin
      req_sync  <= {req_sync[SYNC_DEPTH-2:0], req};
      lock_sync <= {lock_sync[SYNC_DEPTH-2:0], lock};
    end
  end

  // Debounce: a request counts once it has been seen high DEBOUNCE_CYCLES
  // synced samples in a row; any low sample drops it immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this small counter array is reset explicitly (it is not a RAM);
      // a stale count after reset could turn a short glitch into a press.
      for (int i = 0; i < N_REQ; i++) deb_cnt[i] <= '0;
      deb_lvl   <= '0;
      deb_lvl_q <= '0;
    end else begin
      deb_lvl_q <= deb_lvl;
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_s[i]) begin
          deb_cnt[i] <= '0;
          deb_lvl[i] <= 1'b0;
        end else begin
          if (deb_cnt[i] != DW'(DEBOUNCE_CYCLES)) deb_cnt[i] <= deb_cnt[i] + DW'(1);
          deb_lvl[i] <= (deb_cnt[i] == DW'(DEBOUNCE_CYCLES));
        end
      end
    end
  end

  assign req_trig  = deb_lvl & ~deb_lvl_q;
  assign lock_ok   = &lock_s;
  // Lock loss only matters once release has started; WAIT_LOCK already waits.
  assign lock_loss = !lock_ok && (state == RELEASE || state == RUN);
  assign trig_bits = {lock_loss, req_trig};
  assign trig_any  = |trig_bits;

  // Sequencer FSM with registered reset outputs, cause and event count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HOLD;
      hold_cnt    <= '0;
      stage       <= '0;
      gap         <= '0;
      rst_out     <= ALL_ONES;
      busy        <= 1'b1;
      cause       <= '0;
      event_count <= '0;
    end else if (trig_any) begin
      // Any trigger restarts the hold pulse; only a trigger from RUN starts a
      // fresh cause record, otherwise causes pile up until release completes.
      state    <= HOLD;
      hold_cnt <= '0;
      rst_out  <= ALL_ONES;
      busy     <= 1'b1;
      cause    <= (state == RUN) ? trig_bits : (cause | trig_bits);
      if (event_count != 8'hFF) event_count <= event_count + 8'd1;
    end else begin
      case (state)
        HOLD: begin
          if (|deb_lvl) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HW'(PULSE_CYCLES - 1)) begin
            hold_cnt <= '0;
            state    <= WAIT_LOCK;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_ok) begin
            stage <= '0;
            gap   <= '0;
            if (N_STAGES == 1) begin
              state   <= RUN;
              rst_out <= '0;
              busy    <= 1'b0;
            end else begin
              state   <= RELEASE;
              rst_out <= ALL_ONES << 1;
            end
          end
        end
        RELEASE: begin
          if (gap == GW'(STAGE_GAP - 1)) begin
            gap <= '0;
            if (stage == SW'(N_STAGES - 2)) begin
              state   <= RUN;
              rst_out <= '0;
              busy    <= 1'b0;
            end else begin
              stage   <= stage + SW'(1);
              rst_out <= ALL_ONES << (int'(stage) + 2);
            end
          end else begin
            gap <= gap + GW'(1);
          end
        end
        RUN: begin
          rst_out <= '0;
          busy    <= 1'b0;
        end
        default: begin
          state   <= HOLD;
          rst_out <= ALL_ONES;
          busy    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scenario tasks push expected snapshots into a queue
// tagged with the cycle they apply to, then pop and compare them as the run
// reaches that cycle. All driving and sampling happens on the falling edge.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [1:0] lock;
  logic [2:0] rst_out;
  logic       busy;
  logic [2:0] cause;
  logic [7:0] event_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         at;
    logic [2:0] rst;
    bit         meta;
    logic [2:0] cause;
    logic [7:0] cnt;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  reset_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .lock        (lock),
    .rst_out     (rst_out),
    .busy        (busy),
    .cause       (cause),
    .event_count (event_count)
  );

  always #5 clk = ~clk;

  function automatic void push(input int at, input logic [2:0] rst, input bit meta,
                               input logic [2:0] c, input logic [7:0] k, input string tag);
    exp_t e;
    e.at = at; e.rst = rst; e.meta = meta; e.cause = c; e.cnt = k; e.tag = tag;
    exp_q.push_back(e);
  endfunction

  task automatic test_reset();
    exp_t e;
    exp_q.delete();
    push(0,  3'b111, 1, 3'b000, 8'd0, "por_in_reset");
    push(1,  3'b111, 1, 3'b000, 8'd0, "por_cycle0");
    push(31, 3'b111, 0, 3'b000, 8'd0, "por_hold_end");
    push(32, 3'b111, 0, 3'b000, 8'd0, "por_wait_lock");
    push(33, 3'b110, 0, 3'b000, 8'd0, "por_stage0");
    push(36, 3'b110, 0, 3'b000, 8'd0, "por_stage0_end");
    push(37, 3'b100, 0, 3'b000, 8'd0, "por_stage1");
    push(40, 3'b100, 0, 3'b000, 8'd0, "por_stage1_end");
    push(41, 3'b000, 1, 3'b000, 8'd0, "por_run");
    push(45, 3'b000, 1, 3'b000, 8'd0, "por_run_stable");
    reset = 1'b1; req = 2'b00; lock = 2'b11;
    repeat (5) @(posedge clk);
    for (int n = 0; n <= 45; n++) begin
      @(negedge clk);
      if (n == 0) reset = 1'b0;
      while (exp_q.size() != 0 && exp_q[0].at == n) begin
        e = exp_q.pop_front();
        checks++;
        if (rst_out !== e.rst || busy !== (e.rst != 3'b000)) begin
          errors++;
          $display("FAIL %s @%0d: rst_out=%b busy=%b, expected rst_out=%b busy=%b",
                   e.tag, n, rst_out, busy, e.rst, e.rst != 3'b000);
        end
        if (e.meta) begin
          checks++;
          if (cause !== e.cause || event_count !== e.cnt) begin
            errors++;
            $display("FAIL %s @%0d: cause=%b count=%0d, expected cause=%b count=%0d",
                     e.tag, n, cause, event_count, e.cause, e.cnt);
          end
        end
      end
    end
  endtask

  // Short glitch must be ignored; a long press resets and re-releases.
  task automatic test_debounce();
    exp_t e;
    exp_q.delete();
    push(50,  3'b000, 1, 3'b000, 8'd0, "glitch_ignored");
    push(70,  3'b000, 1, 3'b000, 8'd0, "press_before_trig");
    push(71,  3'b111, 1, 3'b001, 8'd1, "press_trig");
    push(125, 3'b111, 0, 3'b000, 8'd0, "press_hold_end");
    push(126, 3'b111, 0, 3'b000, 8'd0, "press_wait_lock");
    push(127, 3'b110, 0, 3'b000, 8'd0, "press_stage0");
    push(130, 3'b110, 0, 3'b000, 8'd0, "press_stage0_end");
    push(131, 3'b100, 0, 3'b000, 8'd0, "press_stage1");
    push(134, 3'b100, 0, 3'b000, 8'd0, "press_stage1_end");
    push(135, 3'b000, 1, 3'b001, 8'd1, "press_run");
    for (int n = 0; n <= 135; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 0)  req[0] = 1'b1;
      if (n == 10) req[0] = 1'b0;
      if (n == 50) req[0] = 1'b1;
      if (n == 90) req[0] = 1'b0;
      while (exp_q.size() != 0 && exp_q[0].at == n) begin
        e = exp_q.pop_front();
        checks++;
        if (rst_out !== e.rst || busy !== (e.rst != 3'b000)) begin
          errors++;
          $display("FAIL %s @%0d: rst_out=%b busy=%b, expected rst_out=%b busy=%b",
                   e.tag, n, rst_out, busy, e.rst, e.rst != 3'b000);
        end
        if (e.meta) begin
          checks++;
          if (cause !== e.cause || event_count !== e.cnt) begin
            errors++;
            $display("FAIL %s @%0d: cause=%b count=%0d, expected cause=%b count=%0d",
                     e.tag, n, cause, event_count, e.cause, e.cnt);
          end
        end
      end
    end
  endtask

  // Lock loss while rst_out=100; reset holds until lock returns.
  task automatic test_lock_loss();
    exp_t e;
    exp_q.delete();
    push(20,  3'b000, 1, 3'b001, 8'd1, "ll_before_trig");
    push(21,  3'b111, 1, 3'b001, 8'd2, "ll_req_trig");
    push(65,  3'b110, 0, 3'b000, 8'd0, "ll_stage0");
    push(66,  3'b100, 0, 3'b000, 8'd0, "ll_stage1");
    push(69,  3'b100, 0, 3'b000, 8'd0, "ll_before_loss");
    push(70,  3'b111, 1, 3'b101, 8'd3, "ll_loss");
    push(115, 3'b111, 1, 3'b101, 8'd3, "ll_wait_lock");
    push(119, 3'b111, 0, 3'b000, 8'd0, "ll_lock_syncing");
    push(120, 3'b110, 0, 3'b000, 8'd0, "ll_rel_stage0");
    push(123, 3'b110, 0, 3'b000, 8'd0, "ll_rel_stage0_end");
    push(124, 3'b100, 0, 3'b000, 8'd0, "ll_rel_stage1");
    push(128, 3'b000, 1, 3'b101, 8'd3, "ll_run");
    for (int n = 0; n <= 128; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 0)   req[0]  = 1'b1;
      if (n == 25)  req[0]  = 1'b0;
      if (n == 66)  lock[1] = 1'b0;
      if (n == 116) lock[1] = 1'b1;
      while (exp_q.size() != 0 && exp_q[0].at == n) begin
        e = exp_q.pop_front();
        checks++;
        if (rst_out !== e.rst || busy !== (e.rst != 3'b000)) begin
          errors++;
          $display("FAIL %s @%0d: rst_out=%b busy=%b, expected rst_out=%b busy=%b",
                   e.tag, n, rst_out, busy, e.rst, e.rst != 3'b000);
        end
        if (e.meta) begin
          checks++;
          if (cause !== e.cause || event_count !== e.cnt) begin
            errors++;
            $display("FAIL %s @%0d: cause=%b count=%0d, expected cause=%b count=%0d",
                     e.tag, n, cause, event_count, e.cause, e.cnt);
          end
        end
      end
    end
  endtask

  // req[1] trigger and lock[0] loss land on the same edge in RUN.
  task automatic test_simultaneous();
    exp_t e;
    exp_q.delete();
    push(20, 3'b000, 1, 3'b101, 8'd3, "sim_before");
    push(21, 3'b111, 1, 3'b110, 8'd4, "sim_trig");
    push(62, 3'b110, 0, 3'b000, 8'd0, "sim_stage0");
    push(66, 3'b100, 0, 3'b000, 8'd0, "sim_stage1");
    push(70, 3'b000, 1, 3'b110, 8'd4, "sim_run");
    for (int n = 0; n <= 70; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 0)  req[1]  = 1'b1;
      if (n == 17) lock[0] = 1'b0;
      if (n == 25) begin
        req[1]  = 1'b0;
        lock[0] = 1'b1;
      end
      while (exp_q.size() != 0 && exp_q[0].at == n) begin
        e = exp_q.pop_front();
        checks++;
        if (rst_out !== e.rst || busy !== (e.rst != 3'b000)) begin
          errors++;
          $display("FAIL %s @%0d: rst_out=%b busy=%b, expected rst_out=%b busy=%b",
                   e.tag, n, rst_out, busy, e.rst, e.rst != 3'b000);
        end
        if (e.meta) begin
          checks++;
          if (cause !== e.cause || event_count !== e.cnt) begin
            errors++;
            $display("FAIL %s @%0d: cause=%b count=%0d, expected cause=%b count=%0d",
                     e.tag, n, cause, event_count, e.cause, e.cnt);
          end
        end
      end
    end
  endtask

  // 260 debounced presses: the count must stop at 255.
  task automatic test_saturation();
    exp_t e;
    int   model_cnt;
    exp_q.delete();
    model_cnt = 4;
    push(20, 3'b000, 1, 3'b110, 8'd4, "sat_first_before");
    for (int p = 0; p < 260; p++) begin
      if (model_cnt < 255) model_cnt++;
      push(p * 28 + 21, 3'b111, 1, 3'b001, 8'(model_cnt), "sat_press");
    end
    for (int n = 0; n < 260 * 28; n++) begin
      if (n > 0) @(negedge clk);
      if (n % 28 == 0)  req[0] = 1'b1;
      if (n % 28 == 22) req[0] = 1'b0;
      while (exp_q.size() != 0 && exp_q[0].at == n) begin
        e = exp_q.pop_front();
        checks++;
        if (rst_out !== e.rst || busy !== (e.rst != 3'b000)) begin
          errors++;
          $display("FAIL %s @%0d: rst_out=%b busy=%b, expected rst_out=%b busy=%b",
                   e.tag, n, rst_out, busy, e.rst, e.rst != 3'b000);
        end
        if (e.meta) begin
          checks++;
          if (cause !== e.cause || event_count !== e.cnt) begin
            errors++;
            $display("FAIL %s @%0d: cause=%b count=%0d, expected cause=%b count=%0d",
                     e.tag, n, cause, event_count, e.cause, e.cnt);
          end
        end
      end
    end
  endtask

  // Block reset asserted during RELEASE restarts from the power-on state.
  task automatic test_reset_mid();
    exp_t e;
    bit   ok;
    exp_q.delete();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rst_out === 3'b110) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mid_wait_release: rst_out=%b, expected 110 within 200 cycles", rst_out);
    end
    push(1,  3'b111, 1, 3'b000, 8'd0, "mid_reset");
    push(33, 3'b111, 0, 3'b000, 8'd0, "mid_wait_lock");
    push(34, 3'b110, 0, 3'b000, 8'd0, "mid_stage0");
    push(38, 3'b100, 0, 3'b000, 8'd0, "mid_stage1");
    push(42, 3'b000, 1, 3'b000, 8'd0, "mid_run");
    for (int n = 0; n <= 42; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 0) reset = 1'b1;
      if (n == 1) reset = 1'b0;
      while (exp_q.size() != 0 && exp_q[0].at == n) begin
        e = exp_q.pop_front();
        checks++;
        if (rst_out !== e.rst || busy !== (e.rst != 3'b000)) begin
          errors++;
          $display("FAIL %s @%0d: rst_out=%b busy=%b, expected rst_out=%b busy=%b",
                   e.tag, n, rst_out, busy, e.rst, e.rst != 3'b000);
        end
        if (e.meta) begin
          checks++;
          if (cause !== e.cause || event_count !== e.cnt) begin
            errors++;
            $display("FAIL %s @%0d: cause=%b count=%0d, expected cause=%b count=%0d",
                     e.tag, n, cause, event_count, e.cause, e.cnt);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_lock_loss();
    test_simultaneous();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
